// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flag_branch_unit
//  Description : Architectural {Z,V,N} flag register fed by the ALU, plus a
//                fixed-latency branch-condition resolver with valid/ready
//                request handshake, flush, and a sticky HLT freeze.
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [3:0] ex_op,
    input  logic [2:0] alu_flags,
    input  logic       br_valid,
    input  logic [2:0] br_ccc,
    input  logic       flush,
    output logic       br_ready,
    output logic [2:0] flags_q,
    output logic       br_resolved,
    output logic       br_taken,
    output logic       halted
);

    // ALU opcodes that matter to the flag register
    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_XOR = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0100;
    localparam logic [3:0] c_OP_SRA = 4'b0101;
    localparam logic [3:0] c_OP_ROR = 4'b0110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    // Branch condition codes
    localparam logic [2:0] c_CC_NEQ = 3'b000;
    localparam logic [2:0] c_CC_EQ  = 3'b001;
    localparam logic [2:0] c_CC_GT  = 3'b010;
    localparam logic [2:0] c_CC_LT  = 3'b011;
    localparam logic [2:0] c_CC_GTE = 3'b100;
    localparam logic [2:0] c_CC_LTE = 3'b101;
    localparam logic [2:0] c_CC_OV  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_flags;
    logic [2:0] r_ccc;
    logic       r_br_resolved;
    logic       r_br_taken;
    logic       r_halted;
    logic       w_accept;
    logic       w_cond;
    logic       w_z;
    logic       w_v;
    logic       w_n;

    assign flags_q     = r_flags;
    assign br_resolved = r_br_resolved;
    assign br_taken    = r_br_taken;
    assign halted      = r_halted;

    assign w_z = r_flags[2];
    assign w_v = r_flags[1];
    assign w_n = r_flags[0];

    // Handshake: ready in IDLE/DONE only; flush beats acceptance
    always_comb begin
        br_ready = ((r_state == S_IDLE) || (r_state == S_DONE)) && !r_halted && !rst;
        w_accept = br_valid && br_ready && !flush;
    end

    // Next-state logic for the resolver
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_EVAL : S_IDLE;
            S_EVAL:  w_state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_EVAL : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Condition evaluation of the captured code against the current flags
    always_comb begin
        w_cond = 1'b1;
        case (r_ccc)
            c_CC_NEQ: w_cond = !w_z;
            c_CC_EQ:  w_cond = w_z;
            c_CC_GT:  w_cond = !w_z && !w_n;
            c_CC_LT:  w_cond = w_n;
            c_CC_GTE: w_cond = w_z || !w_n;
            c_CC_LTE: w_cond = w_z || w_n;
            c_CC_OV:  w_cond = w_v;
            default:  w_cond = 1'b1;
        endcase
    end

    // Resolver state, captured condition code and registered outcome
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ccc         <= 3'b000;
            r_br_resolved <= 1'b0;
            r_br_taken    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ccc <= br_ccc;
            end
            r_br_resolved <= (r_state == S_EVAL) && !flush;
            if ((r_state == S_EVAL) && !flush) begin
                r_br_taken <= w_cond;
            end
        end
    end

    // Flag register: full update for ADD/SUB, Z-only for logic/shift ops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (ex_valid && !r_halted) begin
            case (ex_op)
                c_OP_ADD, c_OP_SUB: r_flags <= alu_flags;
                c_OP_XOR, c_OP_SLL, c_OP_SRA, c_OP_ROR: r_flags[2] <= alu_flags[2];
                default: r_flags <= r_flags;
            endcase
        end
    end

    // Sticky halt, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (ex_valid && (ex_op == c_OP_HLT)) begin
            r_halted <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flag_branch_unit
//  Description : Directed self-checking bench for flag_branch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic [3:0] ex_op;
    logic [2:0] alu_flags;
    logic       br_valid;
    logic [2:0] br_ccc;
    logic       flush;
    logic       br_ready;
    logic [2:0] flags_q;
    logic       br_resolved;
    logic       br_taken;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    flag_branch_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_op       (ex_op),
        .alu_flags   (alu_flags),
        .br_valid    (br_valid),
        .br_ccc      (br_ccc),
        .flush       (flush),
        .br_ready    (br_ready),
        .flags_q     (flags_q),
        .br_resolved (br_resolved),
        .br_taken    (br_taken),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ex_valid  = 1'b0;
        ex_op     = 4'h3;
        alu_flags = 3'b000;
        br_valid  = 1'b0;
        br_ccc    = 3'b000;
        flush     = 1'b0;
    endtask

    // Load flags_q through an ADD
    task automatic load_flags(input logic [2:0] f);
        ex_valid = 1'b1; ex_op = 4'b0000; alu_flags = f;
        step();
        ex_valid = 1'b0;
    endtask

    // Issue one branch from IDLE and check its outcome in the DONE cycle
    task automatic do_branch(input string tag, input logic [2:0] ccc, input logic exp_taken);
        br_valid = 1'b1; br_ccc = ccc;
        step();
        br_valid = 1'b0;
        step();
        chk({tag, "_res"}, {7'd0, br_resolved}, 8'd1);
        chk({tag, "_tkn"}, {7'd0, br_taken}, {7'd0, exp_taken});
        step();
    endtask

    logic [7:0] exp_tbl;

    initial begin
        clr_in();
        rst = 1'b1;
        #1;
        chk("rdy_in_rst", {7'd0, br_ready}, 8'd0);
        step();
        br_valid = 1'b1; br_ccc = 3'b111;
        step();
        chk("rst_flags", {5'd0, flags_q}, 8'h00);
        chk("rst_res", {7'd0, br_resolved}, 8'd0);
        chk("rst_tkn", {7'd0, br_taken}, 8'd0);
        chk("rst_hlt", {7'd0, halted}, 8'd0);
        rst = 1'b0; br_valid = 1'b0;
        #1;
        chk("rdy_idle", {7'd0, br_ready}, 8'd1);

        // ADD saturating (V) with OV branch accepted in the same cycle
        ex_valid = 1'b1; ex_op = 4'b0000; alu_flags = 3'b010;
        br_valid = 1'b1; br_ccc = 3'b110;
        #1;
        chk("ov_rdy", {7'd0, br_ready}, 8'd1);
        step();
        clr_in();
        chk("add_flags", {5'd0, flags_q}, 8'h02);
        chk("ov_eval_res", {7'd0, br_resolved}, 8'd0);
        chk("ov_eval_rdy", {7'd0, br_ready}, 8'd0);
        step();
        chk("ov_res", {7'd0, br_resolved}, 8'd1);
        chk("ov_tkn", {7'd0, br_taken}, 8'd1);
        step();
        chk("ov_pulse_end", {7'd0, br_resolved}, 8'd0);

        // XOR writes Z only
        ex_valid = 1'b1; ex_op = 4'b0010; alu_flags = 3'b101;
        step();
        clr_in();
        chk("xor_flags", {5'd0, flags_q}, 8'h06);

        // SUB in acceptance cycle visible; SUB during EVAL is not
        ex_valid = 1'b1; ex_op = 4'b0001; alu_flags = 3'b100;
        br_valid = 1'b1; br_ccc = 3'b001;
        step();
        clr_in();
        ex_valid = 1'b1; ex_op = 4'b0001; alu_flags = 3'b001;
        step();
        clr_in();
        chk("eq_res", {7'd0, br_resolved}, 8'd1);
        chk("eq_tkn", {7'd0, br_taken}, 8'd1);
        chk("sub_eval_flags", {5'd0, flags_q}, 8'h01);
        step();

        // Condition sweep: taken bit per ccc, hand-derived
        load_flags(3'b000);
        exp_tbl = 8'h95;
        for (int i = 0; i < 8; i++) do_branch($sformatf("f000_cc%0d", i), 3'(i), exp_tbl[i]);
        load_flags(3'b100);
        exp_tbl = 8'hB2;
        for (int i = 0; i < 8; i++) do_branch($sformatf("f100_cc%0d", i), 3'(i), exp_tbl[i]);
        load_flags(3'b001);
        exp_tbl = 8'hA9;
        for (int i = 0; i < 8; i++) do_branch($sformatf("f001_cc%0d", i), 3'(i), exp_tbl[i]);

        // Back-to-back: accept in DONE (flags 001: UNCOND=1 then NEQ=1, EQ=0)
        br_valid = 1'b1; br_ccc = 3'b111;
        step();
        br_valid = 1'b0;
        step();
        br_valid = 1'b1; br_ccc = 3'b001;
        #1;
        chk("b2b_rdy_done", {7'd0, br_ready}, 8'd1);
        chk("b2b_res1", {7'd0, br_resolved}, 8'd1);
        chk("b2b_tkn1", {7'd0, br_taken}, 8'd1);
        step();
        br_valid = 1'b0;
        chk("b2b_eval_res", {7'd0, br_resolved}, 8'd0);
        step();
        chk("b2b_res2", {7'd0, br_resolved}, 8'd1);
        chk("b2b_tkn2", {7'd0, br_taken}, 8'd0);
        step();

        // Flush during EVAL drops the branch
        br_valid = 1'b1; br_ccc = 3'b000;
        step();
        br_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_eval_res", {7'd0, br_resolved}, 8'd0);
        chk("fl_eval_rdy", {7'd0, br_ready}, 8'd1);
        chk("fl_eval_flags", {5'd0, flags_q}, 8'h01);
        step();
        chk("fl_eval_res2", {7'd0, br_resolved}, 8'd0);

        // Flush in the acceptance cycle wins
        br_valid = 1'b1; br_ccc = 3'b111; flush = 1'b1;
        step();
        clr_in();
        step();
        chk("fl_acc_res", {7'd0, br_resolved}, 8'd0);

        // Flush in DONE: pulse stays, offered request is dropped
        br_valid = 1'b1; br_ccc = 3'b111;
        step();
        br_valid = 1'b0;
        step();
        br_valid = 1'b1; br_ccc = 3'b111; flush = 1'b1;
        #1;
        chk("fl_done_res", {7'd0, br_resolved}, 8'd1);
        step();
        clr_in();
        step();
        chk("fl_done_drop", {7'd0, br_resolved}, 8'd0);

        // Reset mid-EVAL: no pulse, flags cleared
        br_valid = 1'b1; br_ccc = 3'b111;
        step();
        br_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_eval_res", {7'd0, br_resolved}, 8'd0);
        chk("rst_eval_flags", {5'd0, flags_q}, 8'h00);
        step();
        chk("rst_eval_res2", {7'd0, br_resolved}, 8'd0);

        // HLT during EVAL: branch completes, unit freezes
        load_flags(3'b010);
        br_valid = 1'b1; br_ccc = 3'b110;
        step();
        br_valid = 1'b0;
        ex_valid = 1'b1; ex_op = 4'b1111;
        step();
        clr_in();
        chk("hlt_set", {7'd0, halted}, 8'd1);
        chk("hlt_rdy", {7'd0, br_ready}, 8'd0);
        chk("hlt_inflight_res", {7'd0, br_resolved}, 8'd1);
        chk("hlt_inflight_tkn", {7'd0, br_taken}, 8'd1);
        ex_valid = 1'b1; ex_op = 4'b0000; alu_flags = 3'b111;
        br_valid = 1'b1; br_ccc = 3'b111;
        step();
        clr_in();
        chk("hlt_add_flags", {5'd0, flags_q}, 8'h02);
        chk("hlt_rdy2", {7'd0, br_ready}, 8'd0);
        step();
        chk("hlt_no_accept", {7'd0, br_resolved}, 8'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("hlt_rst_hlt", {7'd0, halted}, 8'd0);
        chk("hlt_rst_flags", {5'd0, flags_q}, 8'h00);
        chk("hlt_rst_rdy", {7'd0, br_ready}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
